// File: rtl/tdm_demultiplexer.sv
// Round-robin TDM word stream to packed CHANNELS*BUSWIDTH frame; out_valid 1 cycle after the last word, no backpressure.
// TDM_DEMUX_DOUBLEBUF_EN: collect in a shadow register so outlines changes only on frame completion.
module tdm_demultiplexer #(
  parameter int BUSWIDTH    = 8,
  parameter int CHANNELS    = 4,
  parameter int CHANNELBITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BUSWIDTH-1:0]          inlines,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic [CHANNELS*BUSWIDTH-1:0] outlines,
  output logic                         out_valid,
  output logic [CHANNELBITS-1:0]       channel,
  output logic                         locked,
  output logic                         frame_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [CHANNELBITS-1:0] LAST_CH = CHANNELBITS'(CHANNELS - 1);
  localparam logic [CHANNELBITS-1:0] CH_ONE  = CHANNELBITS'(1);

  state_t state;

`ifdef TDM_DEMUX_DOUBLEBUF_EN
  // Last slot is never stored: it goes straight into outlines with the rest.
  logic [(CHANNELS-1)*BUSWIDTH-1:0] shadow;
`endif

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      channel   <= '0;
      outlines  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef TDM_DEMUX_DOUBLEBUF_EN
      shadow    <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_sof) begin
`ifdef TDM_DEMUX_DOUBLEBUF_EN
              shadow[BUSWIDTH-1:0] <= inlines;
`else
              outlines[BUSWIDTH-1:0] <= inlines;
`endif
              channel <= CH_ONE;
              state   <= LOCKED;
            end
          end
          LOCKED: begin
            if (in_sof) begin
              // Early start restarts the frame; the partial one is dropped.
              if (channel != '0) frame_err <= 1'b1;
`ifdef TDM_DEMUX_DOUBLEBUF_EN
              shadow[BUSWIDTH-1:0] <= inlines;
`else
              outlines[BUSWIDTH-1:0] <= inlines;
`endif
              channel <= CH_ONE;
            end else if (channel == '0) begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end else if (channel == LAST_CH) begin
`ifdef TDM_DEMUX_DOUBLEBUF_EN
              outlines <= {inlines, shadow};
`else
              outlines[(CHANNELS-1)*BUSWIDTH +: BUSWIDTH] <= inlines;
`endif
              out_valid <= 1'b1;
              channel   <= '0;
            end else begin
`ifdef TDM_DEMUX_DOUBLEBUF_EN
              shadow[int'(channel)*BUSWIDTH +: BUSWIDTH] <= inlines;
`else
              outlines[int'(channel)*BUSWIDTH +: BUSWIDTH] <= inlines;
`endif
              channel <= channel + CH_ONE;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
